// File: rtl/intra_pkg.sv
// Shared types and constants for the intra prediction engine.
package intra_pkg;

    typedef enum logic [1:0] {
        PM_V   = 2'd0,
        PM_H   = 2'd1,
        PM_DC  = 2'd2,
        PM_DDL = 2'd3
    } pred_mode_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ACC  = 2'd1,
        ST_EMIT = 2'd2
    } state_e;

    function automatic int mid_of(input int w);
        return 1 << (w - 1);
    endfunction

    localparam int PIX_W_DEF = 8;
    localparam int PIX_MID   = mid_of(PIX_W_DEF);

endpackage

// File: rtl/intra_pred_engine_if.sv
// Request/neighbour inputs and valid/ready row stream of the intra prediction engine.
interface intra_pred_engine_if #(
    parameter int BLK   = 16,
    parameter int PIX_W = 8
);
    import intra_pkg::*;

    logic                            start;
    pred_mode_e                      mode;
    logic                            top_avail;
    logic                            left_avail;
    logic [2*BLK-1:0][PIX_W-1:0]     toppixels;
    logic [BLK-1:0][PIX_W-1:0]       leftpixels;
    logic                            busy;
    logic                            out_valid;
    logic                            out_ready;
    logic [BLK-1:0][PIX_W-1:0]       out_row;
    logic [$clog2(BLK)-1:0]          out_row_idx;
    logic                            done;

    modport master (
        output start, mode, top_avail, left_avail, toppixels, leftpixels, out_ready,
        input  busy, out_valid, out_row, out_row_idx, done
    );

    modport slave (
        input  start, mode, top_avail, left_avail, toppixels, leftpixels, out_ready,
        output busy, out_valid, out_row, out_row_idx, done
    );

endinterface

// File: rtl/intra_pred_engine_dc_acc.sv
// DC accumulator: sums one top and one left pixel per enabled cycle, then rounds and shifts
// according to neighbour availability. Result is valid from the cycle after the last add.
module intra_dc_acc
    import intra_pkg::*;
#(
    parameter int BLK   = 16,
    parameter int PIX_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr_i,
    input  logic             en_i,
    input  logic             last_i,
    input  logic             top_avail_i,
    input  logic             left_avail_i,
    input  logic [PIX_W-1:0] top_pix_i,
    input  logic [PIX_W-1:0] left_pix_i,
    output logic [PIX_W-1:0] dc_o,
    output logic             dc_vld_o
);
    localparam int AW = PIX_W + $clog2(BLK) + 1;
    localparam int LB = $clog2(BLK);
    localparam logic [PIX_W-1:0] MID = PIX_W'(mid_of(PIX_W));

    logic [AW-1:0] acc_q, acc_d;
    logic          vld_q, vld_d;
    logic [AW-1:0] addend;
    logic [AW-1:0] sum_r;

    always_ff @(posedge clk) begin
        if (!reset) begin
            acc_q <= '0;
            vld_q <= 1'b0;
        end else begin
            acc_q <= acc_d;
            vld_q <= vld_d;
        end
    end

    always_comb begin
        addend = (top_avail_i  ? AW'(top_pix_i)  : '0)
               + (left_avail_i ? AW'(left_pix_i) : '0);
        acc_d  = acc_q;
        vld_d  = vld_q;
        if (clr_i) begin
            acc_d = '0;
            vld_d = 1'b0;
        end else if (en_i) begin
            acc_d = acc_q + addend;
            if (last_i) begin
                vld_d = 1'b1;
            end
        end
    end

    // Both sides average 2*BLK samples, a single side averages BLK samples.
    always_comb begin
        sum_r = '0;
        dc_o  = MID;
        if (top_avail_i && left_avail_i) begin
            sum_r = acc_q + AW'(BLK);
            dc_o  = PIX_W'(sum_r >> (LB + 1));
        end else if (top_avail_i || left_avail_i) begin
            sum_r = acc_q + AW'(BLK / 2);
            dc_o  = PIX_W'(sum_r >> LB);
        end
    end

    assign dc_vld_o = vld_q;

endmodule

// File: rtl/intra_pred_engine.sv
// Intra predictor (V/H/DC/DDL): captures neighbours on start, streams one row per handshake.
// Row 0 one cycle after start (BLK+1 for DC); rows hold stable while out_ready is low.
module intra_pred_engine
    import intra_pkg::*;
#(
    parameter int BLK   = 16,
    parameter int PIX_W = 8
) (
    input  logic               clk,
    input  logic               reset,
    intra_pred_engine_if.slave bus
);
    localparam int RW = $clog2(BLK);
    localparam int TW = RW + 1;
    localparam logic [PIX_W-1:0] MID  = PIX_W'(mid_of(PIX_W));
    localparam logic [RW-1:0]    LAST = RW'(BLK - 1);

    state_e                      state_q, state_d;
    pred_mode_e                  mode_q;
    logic                        ta_q, la_q;
    logic [2*BLK-1:0][PIX_W-1:0] tp_q;
    logic [BLK-1:0][PIX_W-1:0]   lp_q;
    logic [RW-1:0]               row_q, row_d;
    logic [RW-1:0]               cnt_q, cnt_d;
    logic                        done_q, done_d;
    logic                        cap;
    logic                        hs;
    logic [PIX_W-1:0]            dc_val;
    logic                        dc_vld;
    logic [BLK-1:0][PIX_W-1:0]   row_pix;
    logic [TW-1:0]               i0, i1, i2;
    logic [PIX_W+1:0]            dsum;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            row_q   <= '0;
            cnt_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            row_q   <= row_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            mode_q <= PM_V;
            ta_q   <= 1'b0;
            la_q   <= 1'b0;
            tp_q   <= '0;
            lp_q   <= '0;
        end else if (cap) begin
            mode_q <= bus.mode;
            ta_q   <= bus.top_avail;
            la_q   <= bus.left_avail;
            tp_q   <= bus.top_avail  ? bus.toppixels  : {(2*BLK){MID}};
            lp_q   <= bus.left_avail ? bus.leftpixels : {BLK{MID}};
        end
    end

    always_comb begin
        state_d       = state_q;
        row_d         = row_q;
        cnt_d         = cnt_q;
        done_d        = 1'b0;
        cap           = 1'b0;
        bus.busy      = (state_q != ST_IDLE);
        bus.out_valid = (state_q == ST_EMIT) && ((mode_q != PM_DC) || dc_vld);
        hs            = bus.out_valid && bus.out_ready;
        unique case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    cap     = 1'b1;
                    row_d   = '0;
                    cnt_d   = '0;
                    state_d = (bus.mode == PM_DC) ? ST_ACC : ST_EMIT;
                end
            end
            ST_ACC: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST) begin
                    state_d = ST_EMIT;
                end
            end
            ST_EMIT: begin
                // row_q wraps back to 0 on the final handshake.
                if (hs) begin
                    row_d = row_q + 1'b1;
                    if (row_q == LAST) begin
                        state_d = ST_IDLE;
                        done_d  = 1'b1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    intra_dc_acc #(
        .BLK   (BLK),
        .PIX_W (PIX_W)
    ) u_dc_acc (
        .clk          (clk),
        .reset        (reset),
        .clr_i        (cap),
        .en_i         (state_q == ST_ACC),
        .last_i       (cnt_q == LAST),
        .top_avail_i  (ta_q),
        .left_avail_i (la_q),
        .top_pix_i    (tp_q[TW'(cnt_q)]),
        .left_pix_i   (lp_q[cnt_q]),
        .dc_o         (dc_val),
        .dc_vld_o     (dc_vld)
    );

    // Clamping the third DDL tap at T[2BLK-1] yields the corner case T[2BLK-2] + 3*T[2BLK-1].
    always_comb begin
        row_pix = '0;
        i0      = '0;
        i1      = '0;
        i2      = '0;
        dsum    = '0;
        if (state_q == ST_EMIT) begin
            for (int x = 0; x < BLK; x++) begin
                i0   = TW'(x) + TW'(row_q);
                i1   = i0 + 1'b1;
                i2   = (i1 == TW'(2*BLK - 1)) ? i1 : i1 + 1'b1;
                dsum = {2'b00, tp_q[i0]} + {1'b0, tp_q[i1], 1'b0}
                     + {2'b00, tp_q[i2]} + (PIX_W+2)'(2);
                case (mode_q)
                    PM_V:    row_pix[x] = tp_q[TW'(x)];
                    PM_H:    row_pix[x] = lp_q[row_q];
                    PM_DC:   row_pix[x] = dc_val;
                    default: row_pix[x] = PIX_W'(dsum >> 2);
                endcase
            end
        end
    end

    assign bus.out_row     = row_pix;
    assign bus.out_row_idx = row_q;
    assign bus.done        = done_q;

endmodule
